// File: rtl/sd_pkg.sv
// Shared types and constants for the sd_modn sigma-delta modulator.
// Holds the FSM state encoding, the dither LFSR constants and the feedback-level helpers.
package sd_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } sd_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed for a right-shifting register: bits 0,2,3,5 feed bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic signed [63:0] fb_pos(input int bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fb_neg(input int bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/sd_integ.sv
// One saturating integrator stage: q <= sat(q + din - fb) when en, RESETVAL when en && clear.
// The clamp flag is combinational and reflects the sum that the next enabled edge would store.
module sd_integ
  import sd_pkg::*;
#(
  parameter int IW       = 36,
  parameter int RESETVAL = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clear,
  input  logic signed [IW-1:0] din,
  input  logic signed [IW-1:0] fb,
  output logic signed [IW-1:0] q,
  output logic                 clamp
);

  localparam logic signed [IW-1:0] RST_Q   = IW'(RESETVAL);
  localparam logic signed [IW+1:0] SUM_MAX = {3'b000, {(IW - 1){1'b1}}};
  localparam logic signed [IW+1:0] SUM_MIN = {3'b111, {(IW - 1){1'b0}}};

  // Two guard bits keep q + din - fb exact before the clamp decision.
  logic signed [IW+1:0] sum;
  logic signed [IW-1:0] sat;
  logic                 over_hi;
  logic                 over_lo;

  assign sum = {{2{q[IW-1]}}, q} + {{2{din[IW-1]}}, din} - {{2{fb[IW-1]}}, fb};

  always_comb begin
    over_hi = (sum > SUM_MAX);
    over_lo = (sum < SUM_MIN);
    sat     = sum[IW-1:0];
    if (over_hi) begin
      sat = SUM_MAX[IW-1:0];
    end else if (over_lo) begin
      sat = SUM_MIN[IW-1:0];
    end
  end

  assign clamp = over_hi | over_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_Q;
    end else if (en) begin
      q <= clear ? RST_Q : sat;
    end
  end

endmodule

// File: rtl/sd_modn.sv
// Cascaded-integrator sigma-delta modulator with overload detection and timed recovery.
// Optional input dither from a 16-bit LFSR is built when SD_DITHER_EN is defined.
module sd_modn
  import sd_pkg::*;
#(
  parameter int BW           = 32,
  parameter int ORDER        = 2,
  parameter int IW           = BW + 4,
  parameter int RESETVAL     = 0,
  parameter int OVL_CYCLES   = 8,
  parameter int RECOV_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [BW-1:0] sd_in,
  output logic          bs_out,
  output logic          bs_valid,
  output logic          ovl,
  input  logic          ovl_clr,
  output logic          in_recov
);

  localparam int OCW = $clog2(OVL_CYCLES + 1);
  localparam int RCW = $clog2(RECOV_CYCLES + 1);
  localparam logic signed [IW-1:0] FB_POS = IW'(fb_pos(BW));
  localparam logic signed [IW-1:0] FB_NEG = IW'(fb_neg(BW));

  sd_state_e            state_q, state_d;
  logic [OCW-1:0]       ovl_cnt_q, ovl_cnt_d;
  logic [RCW-1:0]       rec_cnt_q, rec_cnt_d;
  logic                 trigger;
  logic                 integ_clear;
  logic signed [IW-1:0] integ_q [ORDER];
  logic [ORDER-1:0]     clamp_v;
  logic signed [IW-1:0] sd_ext;
  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] fb;

  assign sd_ext = {{(IW - BW){sd_in[BW-1]}}, sd_in};

`ifdef SD_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
  end

  assign x_ext = sd_ext + {{(IW - 1){1'b0}}, lfsr[0]};
`else
  assign x_ext = sd_ext;
`endif

  // Recovery emits an alternating 1,0,1,... pattern; otherwise the sign of the last stage.
  assign in_recov    = (state_q == ST_RECOVER);
  assign bs_out      = in_recov ? ~rec_cnt_q[0] : ~integ_q[ORDER-1][IW-1];
  assign fb          = bs_out ? FB_POS : FB_NEG;
  assign integ_clear = in_recov | trigger;

  for (genvar k = 0; k < ORDER; k++) begin : g_integ
    logic signed [IW-1:0] din;
    if (k == 0) begin : g_first
      assign din = x_ext;
    end else begin : g_next
      assign din = integ_q[k-1];
    end
    sd_integ #(
      .IW       (IW),
      .RESETVAL (RESETVAL)
    ) u_integ (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clear (integ_clear),
      .din   (din),
      .fb    (fb),
      .q     (integ_q[k]),
      .clamp (clamp_v[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    ovl_cnt_d = ovl_cnt_q;
    rec_cnt_d = rec_cnt_q;
    trigger   = 1'b0;
    if (en) begin
      case (state_q)
        ST_RUN: begin
          if (|clamp_v) begin
            if (ovl_cnt_q == OCW'(OVL_CYCLES - 1)) begin
              trigger   = 1'b1;
              state_d   = ST_RECOVER;
              ovl_cnt_d = '0;
              rec_cnt_d = '0;
            end else begin
              ovl_cnt_d = ovl_cnt_q + OCW'(1);
            end
          end else begin
            ovl_cnt_d = '0;
          end
        end
        ST_RECOVER: begin
          if (rec_cnt_q == RCW'(RECOV_CYCLES - 1)) begin
            state_d   = ST_RUN;
            rec_cnt_d = '0;
          end else begin
            rec_cnt_d = rec_cnt_q + RCW'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      ovl_cnt_q <= '0;
      rec_cnt_q <= '0;
      bs_valid  <= 1'b0;
      ovl       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ovl_cnt_q <= ovl_cnt_d;
      rec_cnt_q <= rec_cnt_d;
      bs_valid  <= en;
      // A fresh overload outranks a simultaneous clear request.
      if (trigger) begin
        ovl <= 1'b1;
      end else if (ovl_clr) begin
        ovl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_modn.sv
// Bench for sd_modn: three parameterisations driven in lockstep against an arithmetic model.
// Build with SD_DITHER_EN defined to exercise the dithered variant.
module tb_sd_modn;
  localparam int BW = 8;

  logic       clk = 1'b0;
  logic       reset, en, ovl_clr;
  logic [7:0] sd_in_a, sd_in_b, sd_in_c;
  logic       bs_a, bv_a, ovl_a, rec_a;
  logic       bs_b, bv_b, ovl_b, rec_b;
  logic       bs_c, bv_c, ovl_c, rec_c;

  sd_modn #(.BW(8), .ORDER(1), .IW(12), .RESETVAL(0), .OVL_CYCLES(8), .RECOV_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset), .en(en), .sd_in(sd_in_a), .bs_out(bs_a), .bs_valid(bv_a),
    .ovl(ovl_a), .ovl_clr(ovl_clr), .in_recov(rec_a));
  sd_modn #(.BW(8), .ORDER(2), .IW(12), .RESETVAL(0), .OVL_CYCLES(8), .RECOV_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .en(en), .sd_in(sd_in_b), .bs_out(bs_b), .bs_valid(bv_b),
    .ovl(ovl_b), .ovl_clr(ovl_clr), .in_recov(rec_b));
  sd_modn #(.BW(8), .ORDER(2), .IW(9), .RESETVAL(0), .OVL_CYCLES(4), .RECOV_CYCLES(6)) dut_c (
    .clk(clk), .reset(reset), .en(en), .sd_in(sd_in_c), .bs_out(bs_c), .bs_valid(bv_c),
    .ovl(ovl_c), .ovl_clr(ovl_clr), .in_recov(rec_c));

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // reference model
  int          p_order[3] = '{1, 2, 2};
  int          p_iw[3]    = '{12, 12, 9};
  int          p_ovl[3]   = '{8, 8, 4};
  int          p_rec[3]   = '{16, 16, 6};
  longint      m_i[3][4];
  int          m_cnt[3];
  int          m_rc[3];
  bit          m_rec[3];
  bit          m_ovl[3];
  bit          m_valid;
  logic [15:0] m_lfsr;

  function automatic bit exp_bs(input int m);
    if (m_rec[m]) return (m_rc[m] % 2) == 0;
    return m_i[m][p_order[m]-1] >= 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 4; k++) m_i[m][k] = 0;
      m_cnt[m] = 0;
      m_rc[m]  = 0;
      m_rec[m] = 1'b0;
      m_ovl[m] = 1'b0;
    end
    m_valid = 1'b0;
    m_lfsr  = 16'hACE1;
  endtask

  task automatic model_inst(input int m, input longint x);
    bit     trig = 1'b0;
    bit     any  = 1'b0;
    longint hi, lo, fbv, s;
    longint nv[4];
    if (en) begin
      if (!m_rec[m]) begin
        hi  = (longint'(1) << (p_iw[m] - 1)) - 1;
        lo  = -hi - 1;
        fbv = exp_bs(m) ? ((longint'(1) << (BW - 1)) - 1) : -(longint'(1) << (BW - 1));
        for (int k = 0; k < p_order[m]; k++) begin
          s = m_i[m][k] + ((k == 0) ? x : m_i[m][k-1]) - fbv;
          if (s > hi) begin s = hi; any = 1'b1; end
          else if (s < lo) begin s = lo; any = 1'b1; end
          nv[k] = s;
        end
        m_cnt[m] = any ? m_cnt[m] + 1 : 0;
        if (m_cnt[m] == p_ovl[m]) begin
          trig     = 1'b1;
          m_rec[m] = 1'b1;
          m_rc[m]  = 0;
          m_cnt[m] = 0;
          for (int k = 0; k < 4; k++) m_i[m][k] = 0;
        end else begin
          for (int k = 0; k < p_order[m]; k++) m_i[m][k] = nv[k];
        end
      end else begin
        m_rc[m]++;
        if (m_rc[m] == p_rec[m]) begin
          m_rec[m] = 1'b0;
          m_rc[m]  = 0;
        end
      end
    end
    if (trig) m_ovl[m] = 1'b1;
    else if (ovl_clr) m_ovl[m] = 1'b0;
  endtask

  task automatic model_step();
    longint dith;
    if (reset) begin
      model_reset();
      return;
    end
`ifdef SD_DITHER_EN
    dith = longint'(m_lfsr[0]);
`else
    dith = 0;
`endif
    model_inst(0, longint'($signed(sd_in_a)) + dith);
    model_inst(1, longint'($signed(sd_in_b)) + dith);
    model_inst(2, longint'($signed(sd_in_c)) + dith);
    m_valid = en;
    if (en) m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  task automatic check_all();
    check("a_bs", bs_a, exp_bs(0));  check("a_ovl", ovl_a, m_ovl[0]);
    check("a_recov", rec_a, m_rec[0]); check("a_valid", bv_a, m_valid);
    check("a_i1", dut_a.integ_q[0], m_i[0][0]);
    check("b_bs", bs_b, exp_bs(1));  check("b_ovl", ovl_b, m_ovl[1]);
    check("b_recov", rec_b, m_rec[1]); check("b_valid", bv_b, m_valid);
    check("b_i1", dut_b.integ_q[0], m_i[1][0]); check("b_i2", dut_b.integ_q[1], m_i[1][1]);
    check("c_bs", bs_c, exp_bs(2));  check("c_ovl", ovl_c, m_ovl[2]);
    check("c_recov", rec_c, m_rec[2]); check("c_valid", bv_c, m_valid);
    check("c_i1", dut_c.integ_q[0], m_i[2][0]); check("c_i2", dut_c.integ_q[1], m_i[2][1]);
`ifdef SD_DITHER_EN
    check("lfsr", dut_a.lfsr, m_lfsr);
`endif
  endtask

  // driver
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  function automatic longint in_band(input longint v, input longint lo_v, input longint hi_v);
    return (v < lo_v) ? lo_v : ((v > hi_v) ? hi_v : v);
  endfunction

  int     ones_a, ones_b, cycles, tol_a;
  logic   bs_snap;
  longint i1_snap, i2_snap;

  initial begin
    reset = 1'b1; en = 1'b0; ovl_clr = 1'b0;
    sd_in_a = '0; sd_in_b = '0; sd_in_c = '0;
    model_reset();
    repeat (3) tick();
    check("rst_bs_out", bs_b, 1);
    check("rst_valid", bv_a, 0);

    // steady-state density
    reset = 1'b0; en = 1'b1; sd_in_a = 8'd0; sd_in_b = 8'd64;
    ones_a = 0; ones_b = 0;
`ifdef SD_DITHER_EN
    tol_a = 2;
`else
    tol_a = 1;
`endif
    for (int i = 0; i < 1024; i++) begin
      sd_in_c = 8'($urandom_range(0, 40) - 20);
      tick();
      if (i < 256) ones_a += int'(bs_a);
      ones_b += int'(bs_b);
      if (i == 255) check("a_ovl_idle", ovl_a, 0);
    end
    check("a_ones_256", ones_a, in_band(ones_a, 128 - tol_a, 128 + tol_a));
    check("b_ones_1024", ones_b, in_band(ones_b, 767, 775));

    // enable gap
    bs_snap = bs_b; i1_snap = dut_b.integ_q[0]; i2_snap = dut_b.integ_q[1];
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sd_in_b = 8'($urandom_range(0, 255));
      tick();
      check("gap_bs", bs_b, bs_snap);
      check("gap_i1", dut_b.integ_q[0], i1_snap);
      check("gap_i2", dut_b.integ_q[1], i2_snap);
      check("gap_valid", bv_b, 0);
    end
    en = 1'b1; sd_in_b = 8'd64;

    // forced overload and recovery
    reset = 1'b1; tick(); reset = 1'b0;
    sd_in_c = 8'h80;
    cycles = 0;
    while (!rec_c && cycles < 64) begin tick(); cycles++; end
    check("c_trigger_latency", cycles, 6);
    check("c_ovl_set", ovl_c, 1);
    for (int j = 0; j < 6; j++) begin
      check("c_recov_bs", bs_c, (j % 2) == 0);
      check("c_recov_flag", rec_c, 1);
      check("c_recov_i1", dut_c.integ_q[0], 0);
      check("c_recov_i2", dut_c.integ_q[1], 0);
      tick();
    end
    check("c_recov_exit", rec_c, 0);

    // reset during recovery, then clear coincident with a new trigger
    cycles = 0;
    while (!rec_c && cycles < 64) begin tick(); cycles++; end
    check("d_recov_seen", rec_c, 1);
    tick(); tick();
    reset = 1'b1;
    model_reset();
    #1;
    check("d_reset_recov", rec_c, 0);
    check("d_reset_ovl", ovl_c, 0);
    tick();
    reset = 1'b0; ovl_clr = 1'b1;
    cycles = 0;
    while (!rec_c && cycles < 64) begin tick(); cycles++; end
    check("d_coincident_ovl", ovl_c, 1);
    tick();
    check("d_clear_ovl", ovl_c, 0);
    ovl_clr = 1'b0;

    // random soak
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      ovl_clr = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 199) == 0);
      sd_in_a = 8'($urandom_range(0, 255));
      sd_in_b = 8'($urandom_range(0, 200) - 100);
      sd_in_c = 8'($urandom_range(0, 255));
      tick();
    end
    reset = 1'b0;

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
